ift_trace_recorder: RTL and testbench
=====================================

Name: ift_trace_recorder

Overview:
- Response-side counterpart to the IFT stimulus player.
- The player drives taint vectors into a device under test. This block samples the device's data output and taint output at phase strobes and tags each sample with its vector index and phase.
- Tagged samples are buffered in a small FIFO and drained by a valid/ready reader, so traces can be checked against golden taint records.
- Optional change-only mode records a sample only when the value or its taint differs from the last sample.

Parameters:
- DATA_W, 2, width of the sampled data output q.
- TAINT_W, 32, width of the sampled taint output q_t.
- IDX_W, 3, width of the vector index tag.
- DEPTH, 8, FIFO depth in records; must be a power of 2.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous reset, active-high.
- clear  in  1  synchronous flush of FIFO and statistics.
- sample_en  in  1  one-cycle strobe: capture q/q_t this cycle.
- vec_idx  in  IDX_W  stimulus vector index tag.
- phase  in  2  stimulus phase tag (0..3).
- q  in  DATA_W  device data output being traced.
- q_t  in  TAINT_W  device taint output being traced.
- on_change  in  1  1 = record only on change; 0 = record every strobe.
- rec_valid  out  1  FIFO head holds a record.
- rec_ready  in  1  reader accepts the head record.
- rec_data  out  IDX_W+2+DATA_W+TAINT_W  record {vec_idx, phase, q, q_t}, MSB first.
- count  out  clog2(DEPTH)+1  records currently stored.
- overflow  out  1  sticky: at least one record dropped because the FIFO was full.
- drop_cnt  out  8  dropped records, saturating at 255.

Behaviour:
- Reset (rst=1 at edge):
  - count=0, rec_valid=0, rec_data=0, overflow=0, drop_cnt=0.
  - Read and write pointers = 0; last-sample register = 0; first flag = 1.
- Record candidate: sample_en=1 and (on_change=0 or first=1 or {q,q_t} != last-sample).
- Last-sample register and first flag:
  - On every sample_en, last-sample loads {q,q_t} and first clears to 0.
  - This applies whether or not the candidate is stored or dropped.
- Push: candidate and (count<DEPTH or pop this cycle).
  - Writes {vec_idx,phase,q,q_t} at the write pointer; the pointer wraps modulo DEPTH.
- Pop: rec_valid and rec_ready. Advances the read pointer, with wrap.
- Drop: candidate while count==DEPTH and no pop.
  - overflow is set to 1.
  - drop_cnt increments, saturating at 255.
  - FIFO contents are unchanged.
- Simultaneous push and pop:
  - count is unchanged.
  - Legal when full, because the pop frees a slot.
  - When count==0, push and pop cannot coincide because rec_valid=0.
- Latency:
  - A record pushed at edge N appears with rec_valid=1 and rec_data valid after edge N; there is no bypass of an empty FIFO.
  - rec_data always reflects mem[read pointer] and is stable while rec_valid=1 and rec_ready=0.
- Status outputs:
  - rec_valid = (count != 0).
  - count is registered and updated in the same edge as push/pop.
- clear=1:
  - Takes the same effect as rst on FIFO, pointers, count, overflow, drop_cnt, last-sample and first.
  - Has priority over any push/pop/drop in the same cycle; a strobe in the clear cycle is discarded.
  - Stored memory contents need not be zeroed.
- Reset mid-operation:
  - In-flight records are lost.
  - rec_valid falls to 0 after the reset edge regardless of rec_ready.
- Tags are not checked: vec_idx and phase are recorded as given, and any value is legal.

Test Plan:
- Basic order:
  - Stimulus: on_change=0; 4 strobes with vec_idx=0, phase=0..3, q=0,1,2,3, q_t=32'h1, 32'h2, 32'h4, 32'h8; rec_ready=1 after the 4 strobes.
  - Required: 4 records read in order; the first is {3'd0, 2'd0, 2'b00, 32'h1}; count goes 1,2,3,4 then back to 0.
- Change-only filter:
  - Stimulus: on_change=1; 5 strobes with {q,q_t} = {1,5}, {1,5}, {1,7}, {1,7}, {2,7}.
  - Required: exactly 3 records: {1,5}, {1,7}, {2,7}.
- Overflow:
  - Stimulus: rec_ready=0; 10 strobes with on_change=0.
  - Required: count=8, overflow=1, drop_cnt=2; the reader then gets the first 8 records in order.
- Full with simultaneous push/pop:
  - Stimulus: FIFO full; strobe in the same cycle as rec_ready=1.
  - Required: count stays 8, no drop, overflow stays 0; the new record is the last one read out.
- Clear and reset priority:
  - Stimulus: 5 records stored, then strobe + rec_ready + clear in the same cycle.
  - Required: next cycle count=0, rec_valid=0, drop_cnt=0; the next strobe with on_change=1 is recorded because first=1.
  - Stimulus: repeat using rst instead of clear.
  - Required: identical result.
- Pointer wrap:
  - Stimulus: 20 push/pop pairs interleaved with count held at 1..3.
  - Required: all 20 records are read in order with correct tags, and overflow stays 0.

Source files
------------

// File: rtl/ift_trace_recorder.sv
// ift_trace_recorder
// Response-side trace recorder for IFT taint experiments. On every phase
// strobe it samples the traced device's data output (q) and taint output
// (q_t), tags the sample with the stimulus vector index and phase, and
// pushes the tagged record into a small FIFO drained by a valid/ready reader.
// In change-only mode a strobe is recorded only when {q,q_t} differs from the
// previous strobe (the first strobe after reset/clear is always recorded).
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous reset, active-high
//   clear      in   synchronous flush of FIFO, statistics and change filter
//   sample_en  in   one-cycle strobe: capture q/q_t this cycle
//   vec_idx    in   vector index tag (IDX_W)
//   phase      in   phase tag (2)
//   q          in   traced data output (DATA_W)
//   q_t        in   traced taint output (TAINT_W)
//   on_change  in   1 = record only on change, 0 = record every strobe
//   rec_valid  out  FIFO head holds a record
//   rec_ready  in   reader accepts the head record
//   rec_data   out  head record {vec_idx, phase, q, q_t}, MSB first
//   count      out  records currently stored
//   overflow   out  sticky: a record was dropped on a full FIFO
//   drop_cnt   out  dropped records, saturating at 255
//
// DEPTH must be a power of 2 so the pointers wrap by natural overflow.

module ift_trace_recorder #(
   parameter int DATA_W  = 2,
   parameter int TAINT_W = 32,
   parameter int IDX_W   = 3,
   parameter int DEPTH   = 8
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              clear,
   input  logic                              sample_en,
   input  logic [IDX_W-1:0]                  vec_idx,
   input  logic [1:0]                        phase,
   input  logic [DATA_W-1:0]                 q,
   input  logic [TAINT_W-1:0]                q_t,
   input  logic                              on_change,
   output logic                              rec_valid,
   input  logic                              rec_ready,
   output logic [IDX_W+2+DATA_W+TAINT_W-1:0] rec_data,
   output logic [$clog2(DEPTH):0]            count,
   output logic                              overflow,
   output logic [7:0]                        drop_cnt
);

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int SAMP_W = DATA_W + TAINT_W;
   localparam int REC_W  = IDX_W + 2 + SAMP_W;

   logic [REC_W-1:0]  mem_r [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_r;
   logic [PTR_W-1:0]  rd_ptr_r;
   logic [CNT_W-1:0]  count_r;
   logic              valid_r;
   logic [REC_W-1:0]  head_r;
   logic              overflow_r;
   logic [7:0]        drop_cnt_r;
   logic [SAMP_W-1:0] last_r;
   logic              first_r;

   logic [SAMP_W-1:0] samp_s;
   logic [REC_W-1:0]  wr_data_s;
   logic              full_s;
   logic              cand_s;
   logic              pop_s;
   logic              push_s;
   logic              drop_s;
   logic [PTR_W-1:0]  wr_ptr_nx_s;
   logic [PTR_W-1:0]  rd_ptr_nx_s;
   logic [CNT_W-1:0]  count_nx_s;
   logic [REC_W-1:0]  head_nx_s;
   logic [7:0]        drop_cnt_nx_s;

   // Candidate filtering, push/pop/drop decisions and next-state values.
   always_comb begin
      samp_s        = {q, q_t};
      wr_data_s     = {vec_idx, phase, q, q_t};
      full_s        = (count_r == CNT_W'(DEPTH));
      pop_s         = valid_r & rec_ready;
      cand_s        = 1'b0;
      push_s        = 1'b0;
      drop_s        = 1'b0;
      wr_ptr_nx_s   = wr_ptr_r;
      rd_ptr_nx_s   = rd_ptr_r;
      count_nx_s    = count_r;
      head_nx_s     = '0;
      drop_cnt_nx_s = drop_cnt_r;

      if (sample_en && (!on_change || first_r || (samp_s != last_r))) begin
         cand_s = 1'b1;
      end else begin
         cand_s = 1'b0;
      end

      // A pop in the same cycle frees the slot a full FIFO would otherwise lack.
      push_s = cand_s & (~full_s | pop_s);
      drop_s = cand_s & full_s & ~pop_s;

      if (push_s) begin
         wr_ptr_nx_s = wr_ptr_r + PTR_W'(1);
      end else begin
         wr_ptr_nx_s = wr_ptr_r;
      end

      if (pop_s) begin
         rd_ptr_nx_s = rd_ptr_r + PTR_W'(1);
      end else begin
         rd_ptr_nx_s = rd_ptr_r;
      end

      if (push_s && !pop_s) begin
         count_nx_s = count_r + CNT_W'(1);
      end else if (pop_s && !push_s) begin
         count_nx_s = count_r - CNT_W'(1);
      end else begin
         count_nx_s = count_r;
      end

      // Registered head: forward the write data when it lands in the slot
      // that becomes the new head, since mem is only written at this edge.
      if (count_nx_s == CNT_W'(0)) begin
         head_nx_s = '0;
      end else if (push_s && (wr_ptr_r == rd_ptr_nx_s)) begin
         head_nx_s = wr_data_s;
      end else begin
         head_nx_s = mem_r[rd_ptr_nx_s];
      end

      if (drop_s && (drop_cnt_r != 8'd255)) begin
         drop_cnt_nx_s = drop_cnt_r + 8'd1;
      end else begin
         drop_cnt_nx_s = drop_cnt_r;
      end
   end

   // Control state; clear acts exactly like rst and overrides any strobe.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         wr_ptr_r   <= '0;
         rd_ptr_r   <= '0;
         count_r    <= '0;
         valid_r    <= 1'b0;
         head_r     <= '0;
         overflow_r <= 1'b0;
         drop_cnt_r <= 8'd0;
         last_r     <= '0;
         first_r    <= 1'b1;
      end else begin
         wr_ptr_r   <= wr_ptr_nx_s;
         rd_ptr_r   <= rd_ptr_nx_s;
         count_r    <= count_nx_s;
         valid_r    <= (count_nx_s != CNT_W'(0));
         head_r     <= head_nx_s;
         overflow_r <= overflow_r | drop_s;
         drop_cnt_r <= drop_cnt_nx_s;
         // The change filter tracks every strobe, stored or dropped.
         if (sample_en) begin
            last_r  <= samp_s;
            first_r <= 1'b0;
         end else begin
            last_r  <= last_r;
            first_r <= first_r;
         end
      end
   end

   // Record storage; contents are not cleared, only the pointers are.
   always_ff @(posedge clk) begin
      if (push_s && !rst && !clear) begin
         mem_r[wr_ptr_r] <= wr_data_s;
      end
   end

   assign rec_valid = valid_r;
   assign rec_data  = head_r;
   assign count     = count_r;
   assign overflow  = overflow_r;
   assign drop_cnt  = drop_cnt_r;

endmodule

// File: tb/tb_ift_trace_recorder.sv
module tb_ift_trace_recorder;

   logic        clk;
   logic        rst;
   logic        clear;
   logic        sample_en;
   logic [2:0]  vec_idx;
   logic [1:0]  phase;
   logic [1:0]  q;
   logic [31:0] q_t;
   logic        on_change;
   logic        rec_valid;
   logic        rec_ready;
   logic [38:0] rec_data;
   logic [3:0]  count;
   logic        overflow;
   logic [7:0]  drop_cnt;

   int n_chk;
   int n_fail;
   logic [38:0] exp_q[$];

   ift_trace_recorder #(.DATA_W(2), .TAINT_W(32), .IDX_W(3), .DEPTH(8)) dut (
      .clk(clk), .rst(rst), .clear(clear), .sample_en(sample_en),
      .vec_idx(vec_idx), .phase(phase), .q(q), .q_t(q_t),
      .on_change(on_change), .rec_valid(rec_valid), .rec_ready(rec_ready),
      .rec_data(rec_data), .count(count), .overflow(overflow),
      .drop_cnt(drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic strobe(input logic [2:0] idx, input logic [1:0] ph,
                         input logic [1:0] qv, input logic [31:0] qt, input bit expect_rec);
      vec_idx   = idx;
      phase     = ph;
      q         = qv;
      q_t       = qt;
      sample_en = 1'b1;
      if (expect_rec) exp_q.push_back({idx, ph, qv, qt});
      tick();
      sample_en = 1'b0;
   endtask

   task automatic drain(input string name);
      rec_ready = 1'b1;
      for (int k = 0; k < 40 && (count != 4'd0 || rec_valid); k++) tick();
      rec_ready = 1'b0;
      chk({name, " count"}, 64'(count), 64'd0);
      chk({name, " pending"}, 64'(exp_q.size()), 64'd0);
   endtask

   // Monitor: each accepted head record is compared with the scoreboard.
   always @(negedge clk) begin
      if (!rst && !clear && rec_valid === 1'b1 && rec_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL record: got %0h expected none", rec_data);
         end else begin
            chk("record", 64'(rec_data), 64'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_chk = 0; n_fail = 0;
      rst = 1'b1; clear = 1'b0; sample_en = 1'b0; vec_idx = 3'd0; phase = 2'd0;
      q = 2'd0; q_t = 32'd0; on_change = 1'b0; rec_ready = 1'b0;
      tick(); tick();
      chk("reset count", 64'(count), 64'd0);
      chk("reset valid", 64'(rec_valid), 64'd0);
      chk("reset data", 64'(rec_data), 64'd0);
      chk("reset overflow", 64'(overflow), 64'd0);
      chk("reset drop_cnt", 64'(drop_cnt), 64'd0);
      rst = 1'b0;
      tick();

      // Basic order
      begin
         logic [31:0] qts [4];
         qts[0] = 32'h1; qts[1] = 32'h2; qts[2] = 32'h4; qts[3] = 32'h8;
         for (int i = 0; i < 4; i++) begin
            strobe(3'd0, 2'(i), 2'(i), qts[i], 1'b1);
            chk("basic count", 64'(count), 64'(i + 1));
         end
      end
      chk("basic head", 64'(rec_data), 64'h1);
      chk("basic valid", 64'(rec_valid), 64'd1);
      drain("basic");

      // Change-only filter
      on_change = 1'b1;
      strobe(3'd1, 2'd1, 2'd1, 32'd5, 1'b1);
      strobe(3'd2, 2'd1, 2'd1, 32'd5, 1'b0);
      strobe(3'd3, 2'd1, 2'd1, 32'd7, 1'b1);
      strobe(3'd4, 2'd1, 2'd1, 32'd7, 1'b0);
      strobe(3'd5, 2'd1, 2'd2, 32'd7, 1'b1);
      chk("change count", 64'(count), 64'd3);
      drain("change");
      on_change = 1'b0;

      // Overflow
      for (int i = 0; i < 10; i++)
         strobe(3'(i), 2'(i), 2'(i), 32'h100 + 32'(i), i < 8);
      chk("ovf count", 64'(count), 64'd8);
      chk("ovf flag", 64'(overflow), 64'd1);
      chk("ovf drop_cnt", 64'(drop_cnt), 64'd2);
      drain("ovf");
      chk("ovf sticky", 64'(overflow), 64'd1);
      clear = 1'b1; tick(); clear = 1'b0;
      chk("clear overflow", 64'(overflow), 64'd0);
      chk("clear drop_cnt", 64'(drop_cnt), 64'd0);

      // Full with simultaneous push/pop
      for (int i = 0; i < 8; i++)
         strobe(3'(i), 2'(i), 2'(i), 32'h200 + 32'(i), 1'b1);
      chk("full count", 64'(count), 64'd8);
      rec_ready = 1'b1;
      strobe(3'd7, 2'd3, 2'd3, 32'h2FF, 1'b1);
      rec_ready = 1'b0;
      chk("pp count", 64'(count), 64'd8);
      chk("pp drop_cnt", 64'(drop_cnt), 64'd0);
      chk("pp overflow", 64'(overflow), 64'd0);
      drain("pp");

      // Clear priority over strobe and pop
      for (int i = 0; i < 5; i++)
         strobe(3'(i), 2'd2, 2'(i), 32'h300 + 32'(i), 1'b1);
      chk("clr pre count", 64'(count), 64'd5);
      vec_idx = 3'd6; phase = 2'd1; q = 2'd0; q_t = 32'd0;
      sample_en = 1'b1; rec_ready = 1'b1; clear = 1'b1;
      tick();
      sample_en = 1'b0; rec_ready = 1'b0; clear = 1'b0;
      exp_q.delete();
      chk("clr count", 64'(count), 64'd0);
      chk("clr valid", 64'(rec_valid), 64'd0);
      chk("clr drop_cnt", 64'(drop_cnt), 64'd0);
      on_change = 1'b1;
      strobe(3'd1, 2'd0, 2'd0, 32'd0, 1'b1);
      chk("clr first count", 64'(count), 64'd1);
      drain("clr");
      on_change = 1'b0;

      // Reset priority, entered with drops recorded
      for (int i = 0; i < 10; i++)
         strobe(3'(i), 2'd3, 2'(i), 32'h400 + 32'(i), i < 8);
      chk("rst pre drop_cnt", 64'(drop_cnt), 64'd2);
      vec_idx = 3'd6; phase = 2'd1; q = 2'd0; q_t = 32'd0;
      sample_en = 1'b1; rec_ready = 1'b1; rst = 1'b1;
      tick();
      sample_en = 1'b0; rec_ready = 1'b0; rst = 1'b0;
      exp_q.delete();
      chk("rst count", 64'(count), 64'd0);
      chk("rst valid", 64'(rec_valid), 64'd0);
      chk("rst drop_cnt", 64'(drop_cnt), 64'd0);
      chk("rst overflow", 64'(overflow), 64'd0);
      chk("rst data", 64'(rec_data), 64'd0);
      on_change = 1'b1;
      strobe(3'd2, 2'd0, 2'd0, 32'd0, 1'b1);
      chk("rst first count", 64'(count), 64'd1);
      drain("rst");
      on_change = 1'b0;

      // Pointer wrap: count held at 1..3 over 20 records
      for (int i = 0; i < 20; i++) begin
         rec_ready = (i >= 3);
         strobe(3'(i), 2'(i), 2'(i >> 2), 32'hA000_0000 + 32'(i), 1'b1);
         chk("wrap count", 64'(count), (i < 3) ? 64'(i + 1) : 64'd3);
      end
      rec_ready = 1'b0;
      drain("wrap");
      chk("wrap overflow", 64'(overflow), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
